// File: rtl/serv_alu_pkg.sv
// Shared constants for the digit-serial ALU: rd source indices, boolean op
// encodings with their truth-table LUT, and the legal digit-width check.
package serv_alu_pkg;

  localparam int unsigned RD_ADD  = 0;
  localparam int unsigned RD_SH   = 1;
  localparam int unsigned RD_SLT  = 2;
  localparam int unsigned RD_BOOL = 3;

  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    BOOL_XOR = 2'b00,
    BOOL_EQ  = 2'b01,
    BOOL_OR  = 2'b10,
    BOOL_AND = 2'b11
  } bool_op_e;

  // Indexed by {bool_op, rs1 bit, op_b bit}
  localparam logic [15:0] BOOL_LUT = 16'h8E96;

  function automatic bit legal_w(input int unsigned w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

endpackage

// File: rtl/serv_alu_shifter.sv
// Stored-word shifter: assembles rs1 and the shift amount over a load pass,
// then streams the shifted word out digit by digit on the following pass.
module serv_alu_shifter
  import serv_alu_pkg::*;
#(
  parameter int unsigned W    = 1,
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_cnt0,
  input  logic         i_cnt_done,
  input  logic         i_sh_load,
  input  logic         i_sh_right,
  input  logic         i_sh_signed,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_op_b,
  output logic         o_sh_done,
  output logic [W-1:0] o_digit
);

  localparam int unsigned NDIG = XLEN / W;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [XLEN-1:0]    data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [CW-1:0]      dig_idx;
  logic [XLEN-1:0]    shifted;
  logic [SHAMT_W-1:0] bit_idx;

  always_comb begin
    data_d  = data_q;
    shamt_d = shamt_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    dig_idx = i_cnt0 ? '0 : cnt_q;

    if (i_en) begin
      cnt_d = (dig_idx == CW'(NDIG - 1)) ? '0 : dig_idx + 1'b1;
    end

    if (i_en && i_sh_load) begin
      data_d = {i_rs1, data_q[XLEN-1:W]};
      // Only the digits holding op_b bits 0..4 update the shift amount
      for (int unsigned j = 0; j < SHAMT_W; j++) begin
        for (int unsigned b = 0; b < W; b++) begin
          if (32'(dig_idx) * W + b == j) shamt_d[j] = i_op_b[b];
        end
      end
      if (i_cnt0)     done_d = 1'b0;
      if (i_cnt_done) done_d = 1'b1;
    end

    if (!i_sh_right)      shifted = data_q << shamt_q;
    else if (i_sh_signed) shifted = $unsigned($signed(data_q) >>> shamt_q);
    else                  shifted = data_q >> shamt_q;

    bit_idx = SHAMT_W'(dig_idx) * SHAMT_W'(W);
    o_digit = shifted[bit_idx +: W];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      data_q  <= '0;
      shamt_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      shamt_q <= shamt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign o_sh_done = done_q;

endmodule

// File: rtl/serv_alu_wide.sv
// Digit-serial RV32 ALU: W bits per enabled cycle covering add/sub, eq/lt
// compare, boolean ops, SLT writeback and shifts via the stored-word shifter.
module serv_alu_wide
  import serv_alu_pkg::*;
#(
  parameter int unsigned W    = 1,
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_cnt0,
  input  logic         i_cnt_done,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_rs2,
  input  logic [W-1:0] i_imm,
  input  logic         i_op_b_rs2,
  input  logic         i_sub,
  input  logic [1:0]   i_bool_op,
  input  logic         i_cmp_eq,
  input  logic         i_cmp_uns,
  output logic         o_cmp,
  input  logic         i_sh_load,
  input  logic         i_sh_right,
  input  logic         i_sh_signed,
  output logic         o_sh_done,
  input  logic [3:0]   i_rd_sel,
  output logic [W-1:0] o_rd
);

  if (!legal_w(W) || XLEN != 32) begin : g_bad_param
    $error("serv_alu_wide: W must be 1, 2, 4 or 8 and XLEN must be 32");
  end

  logic [W-1:0] op_b, b_inv, sum, bool_res, sh_digit, slt_dig;
  logic [W:0]   add_full;
  logic         cin, cy, c_msb, ovf, lt, result_eq;
  logic         add_cy_q, add_cy_d, eq_q, eq_d, lt_q, lt_d;

  serv_alu_shifter #(.W(W), .XLEN(XLEN)) u_shifter (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_cnt0      (i_cnt0),
    .i_cnt_done  (i_cnt_done),
    .i_sh_load   (i_sh_load),
    .i_sh_right  (i_sh_right),
    .i_sh_signed (i_sh_signed),
    .i_rs1       (i_rs1),
    .i_op_b      (op_b),
    .o_sh_done   (o_sh_done),
    .o_digit     (sh_digit)
  );

  always_comb begin
    op_b     = i_op_b_rs2 ? i_rs2 : i_imm;
    b_inv    = i_sub ? ~op_b : op_b;
    cin      = i_cnt0 ? i_sub : add_cy_q;
    add_full = {1'b0, i_rs1} + {1'b0, b_inv} + {{W{1'b0}}, cin};
    sum      = add_full[W-1:0];
    cy       = add_full[W];

    // Carry into the MSB recovered from the MSB sum bit
    c_msb     = i_rs1[W-1] ^ b_inv[W-1] ^ sum[W-1];
    ovf       = c_msb ^ cy;
    lt        = i_cmp_uns ? ~cy : (sum[W-1] ^ ovf);
    result_eq = (i_rs1 == op_b) & (i_cnt0 | eq_q);
    o_cmp     = i_cmp_eq ? result_eq : lt;

    for (int unsigned b = 0; b < W; b++) begin
      bool_res[b] = BOOL_LUT[{i_bool_op, i_rs1[b], op_b[b]}];
    end

    slt_dig    = '0;
    slt_dig[0] = lt_q & i_cnt0;

    o_rd = '0;
    if (i_rd_sel[RD_ADD])                o_rd |= sum;
    if (i_rd_sel[RD_SH] && !i_sh_load)   o_rd |= sh_digit;
    if (i_rd_sel[RD_SLT])                o_rd |= slt_dig;
    if (i_rd_sel[RD_BOOL])               o_rd |= bool_res;

    add_cy_d = i_en & cy;
    eq_d     = i_en ? result_eq : 1'b1;
    lt_d     = (i_en && i_cnt_done) ? lt : lt_q;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      add_cy_q <= 1'b0;
      eq_q     <= 1'b1;
      lt_q     <= 1'b0;
    end else begin
      add_cy_q <= add_cy_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

endmodule

// File: tb/tb_serv_alu_wide.sv
// Scoreboard bench for serv_alu_wide at W=4: stimulus queues expected words,
// a negedge monitor assembles rd digits / samples flags and compares.
module tb_serv_alu_wide;
  import serv_alu_pkg::*;

  localparam int unsigned DW   = 4;
  localparam int unsigned NDIG = 32 / DW;

  logic          clk = 1'b0;
  logic          i_rst, i_en, i_cnt0, i_cnt_done;
  logic [DW-1:0] i_rs1, i_rs2, i_imm;
  logic          i_op_b_rs2, i_sub, i_cmp_eq, i_cmp_uns;
  logic [1:0]    i_bool_op;
  logic          i_sh_load, i_sh_right, i_sh_signed;
  logic [3:0]    i_rd_sel;
  logic          o_cmp, o_sh_done;
  logic [DW-1:0] o_rd;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        mon_rd = 1'b0, mon_cmp = 1'b0, mon_done = 1'b0, mon_dig = 1'b0;
  logic [31:0] mon_word = '0;

  serv_alu_wide #(.W(DW), .XLEN(32)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_cnt0      (i_cnt0),
    .i_cnt_done  (i_cnt_done),
    .i_rs1       (i_rs1),
    .i_rs2       (i_rs2),
    .i_imm       (i_imm),
    .i_op_b_rs2  (i_op_b_rs2),
    .i_sub       (i_sub),
    .i_bool_op   (i_bool_op),
    .i_cmp_eq    (i_cmp_eq),
    .i_cmp_uns   (i_cmp_uns),
    .o_cmp       (o_cmp),
    .i_sh_load   (i_sh_load),
    .i_sh_right  (i_sh_right),
    .i_sh_signed (i_sh_signed),
    .o_sh_done   (o_sh_done),
    .i_rd_sel    (i_rd_sel),
    .o_rd        (o_rd)
  );

  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [31:0] e);
    exp_t r;
    r.name = nm;
    r.exp  = e;
    sb_q.push_back(r);
  endtask

  task automatic check(input logic [31:0] act);
    exp_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_output actual=%h required=none", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  endtask

  // Monitor: rd words are assembled LSB digit first and checked on the last digit
  always @(negedge clk) begin
    if (i_en && mon_rd) begin
      mon_word = {o_rd, mon_word[31:DW]};
      if (i_cnt_done) check(mon_word);
    end
    if (i_en && mon_cmp && i_cnt_done) check(32'(o_cmp));
    if (mon_done) check(32'(o_sh_done));
    if (mon_dig)  check(32'(o_rd));
  end

  task automatic run_pass(input logic [31:0] a, input logic [31:0] b,
                          input bit mrd, input bit mcmp);
    for (int k = 0; k < NDIG; k++) begin
      @(posedge clk); #1;
      i_en       = 1'b1;
      i_cnt0     = (k == 0);
      i_cnt_done = (k == NDIG - 1);
      i_rs1      = a[k*DW +: DW];
      if (i_op_b_rs2) begin
        i_rs2 = b[k*DW +: DW];
        i_imm = ~b[k*DW +: DW];
      end else begin
        i_imm = b[k*DW +: DW];
        i_rs2 = ~b[k*DW +: DW];
      end
      mon_rd  = mrd;
      mon_cmp = mcmp;
    end
    @(posedge clk); #1;
    i_en = 1'b0; i_cnt0 = 1'b0; i_cnt_done = 1'b0;
    mon_rd = 1'b0; mon_cmp = 1'b0;
  endtask

  task automatic one_digit(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit cd, input bit mdig, input bit mcmp);
    @(posedge clk); #1;
    i_en = 1'b1; i_cnt0 = 1'b0; i_cnt_done = cd;
    i_rs1 = a; i_rs2 = b; i_imm = b;
    mon_dig = mdig; mon_cmp = mcmp;
    @(posedge clk); #1;
    i_en = 1'b0; i_cnt_done = 1'b0; mon_dig = 1'b0; mon_cmp = 1'b0;
  endtask

  task automatic probe_done();
    @(posedge clk); #1;
    mon_done = 1'b1;
    @(posedge clk); #1;
    mon_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  bops [8] = '{BOOL_AND, BOOL_OR, BOOL_XOR, BOOL_EQ,
                              BOOL_AND, BOOL_OR, BOOL_XOR, BOOL_EQ};
    logic [31:0] bas  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00};
    logic [31:0] bexp [8] = '{32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'hF0F0F0F0,
                              32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'hF00FF00F};
    exp_t e;

    i_rst = 1'b1; i_en = 1'b0; i_cnt0 = 1'b0; i_cnt_done = 1'b0;
    i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_op_b_rs2 = 1'b0; i_sub = 1'b0;
    i_bool_op = 2'b00; i_cmp_eq = 1'b0; i_cmp_uns = 1'b0;
    i_sh_load = 1'b0; i_sh_right = 1'b0; i_sh_signed = 1'b0; i_rd_sel = 4'b0000;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;

    // Reset state and rd gating with no source selected
    push("rst_sh_done", 32'h0); probe_done();
    i_rs1 = '1; i_rs2 = '1; i_imm = '1;
    push("rd_sel_none", 32'h0);
    @(posedge clk); #1 mon_dig = 1'b1;
    @(posedge clk); #1 mon_dig = 1'b0;

    // Add / sub
    i_rd_sel = 4'b0001; i_op_b_rs2 = 1'b0; i_sub = 1'b0;
    push("add_7fffffff_1", 32'h80000000); run_pass(32'h7FFFFFFF, 32'h1, 1, 0);
    i_op_b_rs2 = 1'b1; i_sub = 1'b1;
    push("sub_5_7", 32'hFFFFFFFE); run_pass(32'd5, 32'd7, 1, 0);
    push("sub_9_2", 32'h00000007); run_pass(32'd9, 32'd2, 1, 0);
    i_sub = 1'b0;
    push("carry_cleared_idle", 32'h0); one_digit('0, '0, 1'b0, 1'b1, 1'b0);

    // Compares and SLT writeback
    i_rd_sel = 4'b0000; i_sub = 1'b1; i_cmp_eq = 1'b0; i_cmp_uns = 1'b0;
    push("slt_m1_1", 32'h1); run_pass(32'hFFFFFFFF, 32'h1, 0, 1);
    i_rd_sel = 4'b0100;
    push("slt_wb_1", 32'h1); run_pass(32'h0, 32'h0, 1, 0);
    i_rd_sel = 4'b0000; i_cmp_uns = 1'b1;
    push("sltu_m1_1", 32'h0); run_pass(32'hFFFFFFFF, 32'h1, 0, 1);
    i_rd_sel = 4'b0100;
    push("sltu_wb_0", 32'h0); run_pass(32'h0, 32'h0, 1, 0);
    i_rd_sel = 4'b0000; i_cmp_uns = 1'b0;
    push("slt_5_min", 32'h0); run_pass(32'd5, 32'h80000000, 0, 1);
    i_cmp_uns = 1'b1;
    push("sltu_5_min", 32'h1); run_pass(32'd5, 32'h80000000, 0, 1);
    i_cmp_eq = 1'b1;
    push("eq_same", 32'h1);    run_pass(32'h12345678, 32'h12345678, 0, 1);
    push("eq_diff_d0", 32'h0); run_pass(32'h12345679, 32'h12345678, 0, 1);
    push("eq_diff_d5", 32'h0); run_pass(32'h12945678, 32'h12345678, 0, 1);

    // Shifts
    i_cmp_eq = 1'b0; i_cmp_uns = 1'b0; i_sub = 1'b0; i_op_b_rs2 = 1'b0;
    i_rd_sel = 4'b0010;
    i_sh_load = 1'b1; run_pass(32'h80000000, 32'd4, 0, 0);
    push("sh_done_set", 32'h1); probe_done();
    i_sh_load = 1'b0; i_sh_right = 1'b1; i_sh_signed = 1'b1;
    push("sra_4", 32'hF8000000); run_pass(32'h0, 32'h0, 1, 0);
    i_sh_signed = 1'b0;
    push("srl_4", 32'h08000000); run_pass(32'h0, 32'h0, 1, 0);
    i_sh_load = 1'b1; run_pass(32'h80000000, 32'hABCDEF1F, 0, 0);
    i_sh_load = 1'b0; i_sh_signed = 1'b1;
    push("sra_31", 32'hFFFFFFFF); run_pass(32'h0, 32'h0, 1, 0);
    i_sh_load = 1'b1; run_pass(32'h00000001, 32'hABCDEF1F, 0, 0);
    i_sh_load = 1'b0; i_sh_right = 1'b0; i_sh_signed = 1'b0;
    push("sll_31", 32'h80000000); run_pass(32'h0, 32'h0, 1, 0);
    i_sh_load = 1'b1; run_pass(32'h12345678, 32'hFFFFFFE0, 0, 0);
    i_sh_load = 1'b0; i_sh_right = 1'b1; i_sh_signed = 1'b1;
    push("sra_0", 32'h12345678); run_pass(32'h0, 32'h0, 1, 0);
    i_sh_right = 1'b0; i_sh_signed = 1'b0;

    // Reset on digit 3 of an add 3 + 4, leaving eq_r cleared beforehand
    i_rd_sel = 4'b0001; i_op_b_rs2 = 1'b0; i_sub = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      i_en = 1'b1; i_cnt0 = (k == 0); i_cnt_done = 1'b0;
      i_rs1 = (k == 0) ? 4'd3 : 4'd0;
      i_imm = (k == 0) ? 4'd4 : 4'd0;
      i_rst = (k == 3);
    end
    @(posedge clk); #1;
    i_rst = 1'b0; i_en = 1'b0; i_cnt0 = 1'b0;
    i_rd_sel = 4'b0000; i_cmp_eq = 1'b1;
    push("rst_eq_r", 32'h1); one_digit('0, '0, 1'b1, 1'b0, 1'b1);
    i_cmp_eq = 1'b0;
    push("rst_sh_done_clr", 32'h0); probe_done();
    i_rd_sel = 4'b0001;
    push("add_3_4_after_rst", 32'd7); run_pass(32'd3, 32'd4, 1, 0);

    // Boolean ops
    i_rd_sel = 4'b1000; i_op_b_rs2 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      i_bool_op = bops[t];
      push($sformatf("bool_%0d_op%0d", t, bops[t]), bexp[t]);
      run_pass(bas[t], 32'hF0F0F0F0, 1, 0);
    end
    i_rd_sel = 4'b0000;

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s actual=none required=%h", e.name, e.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
